// File: rtl/bch_enc_ctrl.sv
// Sequencer and parity engine for a serial BCH(63,51,t=2) encoder driving a 63-bit SIPO collector.
// Latency: 1 start cycle + 51 message cycles (plus stalls) + 12 parity cycles; cw_valid lands in cycle 64 with no stalls.
// Backpressure: the upstream source may stall indefinitely in MSG (in_valid=0); parity output never stalls.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   start            begin a codeword (sampled only in IDLE; ignored while busy)
//   in_bit/in_valid  serial message, highest degree first; in_ready is high only in MSG
//   sipo_bit         serial data to the collector (message bits, then parity MSB first)
//   sipo_hold        collector hold; 0 means the collector shifts this cycle
//   sipo_rst         synchronous clear to the collector, high in the start cycle
//   busy             registered; high from the cycle after start through DONE
//   cw_valid         registered one-cycle strobe; collector holds the full codeword
//   parity           registered parity of the last completed codeword
//   abort            present only when BCH_CTRL_ABORT_EN is defined; abandons the codeword in MSG/PAR
//
// Build option: define BCH_CTRL_ABORT_EN to add the abort input.
// CNT_W must satisfy 2**CNT_W >= N.

module bch_enc_ctrl #(
    parameter int               N        = 63,
    parameter int               K        = 51,
    parameter logic [N-K-1:0]   GEN_POLY = 12'h539,
    parameter int               CNT_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sipo_bit,
    output logic             sipo_hold,
    output logic             sipo_rst,
    output logic             busy,
    output logic             cw_valid,
    output logic [N-K-1:0]   parity
`ifdef BCH_CTRL_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int P = N - K;

    // Terminal counts for the message and parity phases.
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(P - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MSG  = 2'd1,
        S_PAR  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [P-1:0]      lfsr;

    logic              abort_act;
    logic              accept;
    logic              par_shift;
    logic              fb;

`ifdef BCH_CTRL_ABORT_EN
    // Abort only matters while a codeword is in flight.
    assign abort_act = abort && ((state == S_MSG) || (state == S_PAR));
`else
    assign abort_act = 1'b0;
`endif

    // Abort wins over a same-cycle message bit, so nothing reaches the collector that cycle.
    assign accept    = (state == S_MSG) && in_valid && !abort_act;
    assign par_shift = (state == S_PAR) && !abort_act;

    // Division by g(x): the feedback term is the incoming bit plus the top remainder bit.
    assign fb = in_bit ^ lfsr[P-1];

    assign in_ready  = (state == S_MSG);
    assign sipo_hold = !(accept || par_shift);
    assign sipo_rst  = (state == S_IDLE) && start;

    always_comb begin
        sipo_bit = 1'b0;
        if (accept) begin
            sipo_bit = in_bit;
        end else if (par_shift) begin
            sipo_bit = lfsr[P-1];
        end
    end

    // In PAR the remainder is rotated rather than zero-filled: the emitted bit
    // stream is identical, and after the last emission the rotation brings the
    // complete remainder back into position so it can be latched into parity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lfsr     <= '0;
            parity   <= '0;
            busy     <= 1'b0;
            cw_valid <= 1'b0;
        end else begin
            cw_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_MSG;
                        lfsr  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                S_MSG: begin
                    if (abort_act) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (in_valid) begin
                        lfsr <= {lfsr[P-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
                        if (cnt == MSG_LAST) begin
                            cnt   <= '0;
                            state <= S_PAR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                S_PAR: begin
                    if (abort_act) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        lfsr <= {lfsr[P-2:0], lfsr[P-1]};
                        if (cnt == PAR_LAST) begin
                            // One more rotation of the current value restores the full remainder.
                            parity   <= {lfsr[P-2:0], lfsr[P-1]};
                            cw_valid <= 1'b1;
                            cnt      <= '0;
                            state    <= S_DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bch_enc_ctrl.sv
// Directed bench for bch_enc_ctrl with a behavioural model of the 63-bit SIPO collector.
// Drives inputs 1 time unit after the rising edge, samples on the falling edge.
// Expected parities are hand-computed remainders of m(x)*x^12 mod g(x).

module tb_bch_enc_ctrl;

    localparam int K = 51;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic        sipo_bit;
    logic        sipo_hold;
    logic        sipo_rst;
    logic        busy;
    logic        cw_valid;
    logic [11:0] parity;
    logic        abort;

    int n_checks = 0;
    int n_fail   = 0;
    int cw_pulses = 0;

    logic [62:0] col = '0;

    always #5 clk = ~clk;

    bch_enc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sipo_bit  (sipo_bit),
        .sipo_hold (sipo_hold),
        .sipo_rst  (sipo_rst),
        .busy      (busy),
        .cw_valid  (cw_valid),
        .parity    (parity)
`ifdef BCH_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // Downstream collector: first shifted bit ends at bit 0 after 63 shifts.
    always @(posedge clk) begin
        if (sipo_rst) col <= '0;
        else if (!sipo_hold) col <= {sipo_bit, col[62:1]};
    end

    always @(negedge clk) begin
        if (cw_valid) cw_pulses <= cw_pulses + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string        name;
        logic [50:0]  msg;
        bit           stall_en;
        int           start_at;
        logic [11:0]  exp_par;
    } vec_t;

    vec_t vecs[7];

    // Expected collector image: message m50..m0 at bits 0..50, parity p11..p0 at bits 51..62.
    function automatic logic [62:0] exp_collector(input logic [50:0] msg, input logic [11:0] par);
        logic [62:0] r;
        for (int i = 0; i < 51; i++) r[i] = msg[50 - i];
        for (int j = 0; j < 12; j++) r[51 + j] = par[11 - j];
        return r;
    endfunction

    task automatic run_cw(input vec_t v);
        int bi, stall_left, c, stalls, lat, pulses0;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; in_bit = 1'b0; abort = 1'b0;
        @(negedge clk);
        check({v.name, ":sipo_rst_start"}, sipo_rst, 1);
        check({v.name, ":busy_before"}, busy, 0);
        c = 0; bi = 0; stall_left = 0; stalls = 0; lat = -1;
        pulses0 = cw_pulses;
        while (lat < 0 && c < 400) begin
            @(posedge clk); c++; #1;
            start = (v.start_at >= 0 && c == v.start_at);
            if (bi < K) begin
                if (stall_left > 0) begin
                    in_valid = 1'b0; stall_left--; stalls++;
                end else begin
                    in_valid = 1'b1; in_bit = v.msg[K - 1 - bi];
                end
            end else begin
                // Valid data offered during PAR/DONE must not be consumed.
                in_valid = 1'b1; in_bit = 1'b1;
            end
            @(negedge clk);
            if (bi < K) begin
                check({v.name, ":in_ready_msg"}, in_ready, 1);
                check({v.name, ":hold_msg"}, sipo_hold, !in_valid);
                if (start) check({v.name, ":rst_ignored_busy"}, sipo_rst, 0);
                if (in_valid) begin
                    bi++;
                    if (v.stall_en && (bi % 5 == 0)) stall_left = 3;
                end
            end else begin
                check({v.name, ":in_ready_par"}, in_ready, 0);
                if (!cw_valid) check({v.name, ":shift_par"}, sipo_hold, 0);
            end
            if (cw_valid) lat = c;
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s:cw_valid_timeout actual=none required=%0d", v.name, 64 + stalls);
        end else begin
            check({v.name, ":latency"}, lat, 64 + stalls);
            check({v.name, ":parity"}, parity, v.exp_par);
            check({v.name, ":busy_done"}, busy, 1);
            check({v.name, ":hold_done"}, sipo_hold, 1);
            check({v.name, ":collector"}, col, exp_collector(v.msg, v.exp_par));
        end
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({v.name, ":cw_valid_1cyc"}, cw_valid, 0);
        check({v.name, ":busy_idle"}, busy, 0);
        check({v.name, ":in_ready_idle"}, in_ready, 0);
        check({v.name, ":hold_idle"}, sipo_hold, 1);
        check({v.name, ":cw_pulses"}, cw_pulses - pulses0, 1);
        check({v.name, ":collector_stable"}, col, exp_collector(v.msg, v.exp_par));
        in_valid = 1'b0;
    endtask

    initial begin
        logic [50:0] m_reset;
        int pulses0;

        vecs[0] = '{"zeros",        51'd0, 1'b0, -1, 12'h000};
        vecs[1] = '{"m0",           51'd1, 1'b0, -1, 12'h539};
        vecs[2] = '{"m0_stall",     51'd1, 1'b1, -1, 12'h539};
        vecs[3] = '{"zeros_start",  51'd0, 1'b0, 20, 12'h000};
        vecs[4] = '{"m1",           51'd2, 1'b0, -1, 12'hA72};
        vecs[5] = '{"m2",           51'd4, 1'b0, -1, 12'h1DD};
        vecs[6] = '{"m0m1_start",   51'd3, 1'b0, 20, 12'hF4B};

        reset = 1'b0; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0; abort = 1'b0;
        #13;
        check("rst:in_ready", in_ready, 0);
        check("rst:sipo_hold", sipo_hold, 1);
        check("rst:sipo_bit", sipo_bit, 0);
        check("rst:sipo_rst", sipo_rst, 0);
        check("rst:busy", busy, 0);
        check("rst:cw_valid", cw_valid, 0);
        check("rst:parity", parity, 0);

        @(posedge clk); #1; reset = 1'b1;
        // in_valid in IDLE is ignored.
        in_valid = 1'b1; in_bit = 1'b1;
        @(negedge clk);
        check("idle:in_ready", in_ready, 0);
        check("idle:hold", sipo_hold, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle:busy", busy, 0);
        in_valid = 1'b0;

        foreach (vecs[i]) run_cw(vecs[i]);

        // Reset in the middle of a message: partial codeword is discarded.
        m_reset = 51'h7_FFFF_FFFF_FFFF;
        @(posedge clk); #1; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b1; in_bit = m_reset[K - c];
        end
        pulses0 = cw_pulses;
        @(posedge clk); #1; reset = 1'b0;
        #1;
        check("midrst:busy", busy, 0);
        check("midrst:in_ready", in_ready, 0);
        check("midrst:hold", sipo_hold, 1);
        check("midrst:parity", parity, 0);
        repeat (3) @(posedge clk);
        #1; reset = 1'b1; in_valid = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        check("midrst:no_cw_valid", cw_pulses - pulses0, 0);
        check("midrst:busy_after", busy, 0);
        run_cw(vecs[4]);

`ifdef BCH_CTRL_ABORT_EN
        // Abort on the 4th parity cycle; parity keeps the previous codeword's value.
        @(posedge clk); #1; start = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = (c <= K); in_bit = (c == K) || (c == K - 1);
            abort = (c == 55);
            if (c == 55) begin
                @(negedge clk);
                check("abort:hold", sipo_hold, 1);
            end
        end
        pulses0 = cw_pulses;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("abort:busy", busy, 0);
        check("abort:in_ready", in_ready, 0);
        repeat (70) @(posedge clk);
        #1;
        check("abort:no_cw_valid", cw_pulses - pulses0, 0);
        check("abort:parity_kept", parity, vecs[4].exp_par);
        run_cw(vecs[6]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
